// File: rtl/jtdsp16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtdsp16_pkg
// Brief    : Shared types and constants for the DSP16 external program port.
// Revision : 1.0  initial release
// ============================================================================
package jtdsp16_pkg;

  localparam int EXT_AW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LSB  = 2'd1,
    MSB  = 2'd2
  } rom_state_e;

endpackage
`default_nettype wire

// File: rtl/jtdsp16_ext_rom.sv
`default_nettype none
// ============================================================================
// Module   : jtdsp16_ext_rom
// Brief    : DSP16 external program-memory responder; assembles 16-bit words
//            from a byte-wide system ROM and keeps a one-word cache.
// Revision : 1.0  initial release
// ============================================================================
module jtdsp16_ext_rom
  import jtdsp16_pkg::*;
#(
  parameter int              AW   = 22,
  parameter logic [AW-1:0]   BASE = '0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_rq,
  input  logic [EXT_AW-1:0] ext_addr,
  output logic [15:0]       ext_data,
  output logic              ext_ok,
  input  logic              flush,
  output logic              sys_cs,
  output logic [AW-1:0]     sys_addr,
  input  logic [7:0]        sys_data,
  input  logic              sys_ok
);

  rom_state_e        r_state;
  rom_state_e        w_state_nx;
  logic              r_blind;
  logic [7:0]        r_lsb;
  logic [EXT_AW-1:0] r_tag;
  logic [EXT_AW-1:0] r_req_addr;
  logic              r_valid;

  logic              w_hit;
  logic              w_start;
  logic              w_lsb_done;
  logic              w_msb_done;
  logic [AW-1:0]     w_lsb_addr;

  // Word address doubled into a byte address; the sum wraps at AW bits.
  assign w_lsb_addr = BASE + AW'({ext_addr, 1'b0});
  assign w_hit      = r_valid && (r_tag == ext_addr);
  assign ext_ok     = ext_rq && w_hit && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // sys_ok seen right after an address change belongs to the previous byte,
  // so the first cycle in LSB/MSB (r_blind) never completes a byte.
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_lsb_done = 1'b0;
    w_msb_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (ext_rq && !w_hit) begin
          w_start    = 1'b1;
          w_state_nx = LSB;
        end
      end
      LSB: begin
        if (!r_blind && sys_ok) begin
          w_lsb_done = 1'b1;
          w_state_nx = MSB;
        end
      end
      MSB: begin
        if (!r_blind && sys_ok) begin
          w_msb_done = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_data   <= '0;
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_req_addr <= '0;
      r_lsb      <= '0;
      r_blind    <= 1'b0;
      sys_cs     <= 1'b0;
      sys_addr   <= BASE;
    end else begin
      r_blind <= w_start | w_lsb_done;
      if (w_start) begin
        r_req_addr <= ext_addr;
        sys_addr   <= w_lsb_addr;
        sys_cs     <= 1'b1;
      end
      if (w_lsb_done) begin
        r_lsb    <= sys_data;
        sys_addr <= sys_addr + AW'(1);
      end
      if (w_msb_done) begin
        ext_data <= {sys_data, r_lsb};
        r_tag    <= r_req_addr;
        r_valid  <= 1'b1;
        sys_cs   <= 1'b0;
      end
      // Flush takes priority over a fill completing in the same cycle.
      if (flush) r_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_ext_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtdsp16_ext_rom
// Brief    : Directed self-checking bench for jtdsp16_ext_rom.
// Revision : 1.0  initial release
// ============================================================================
module tb_jtdsp16_ext_rom;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ext_rq, flush, sys_ok;
  logic [15:0] ext_addr;
  logic [7:0]  sys_data;
  logic [15:0] ext_data;
  logic        ext_ok, sys_cs;
  logic [21:0] sys_addr;

  logic        ext_rq_w;
  logic [15:0] ext_addr_w;
  logic [15:0] ext_data_w;
  logic        ext_ok_w, sys_cs_w;
  logic [21:0] sys_addr_w;
  logic        sys_ok_w   = 1'b1;
  logic [7:0]  sys_data_w = 8'h77;
  logic        flush_w    = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int max_delay = 0;

  jtdsp16_ext_rom #(.AW(22), .BASE(22'h0)) dut (
    .clk(clk), .rst(rst), .ext_rq(ext_rq), .ext_addr(ext_addr),
    .ext_data(ext_data), .ext_ok(ext_ok), .flush(flush),
    .sys_cs(sys_cs), .sys_addr(sys_addr), .sys_data(sys_data), .sys_ok(sys_ok)
  );

  jtdsp16_ext_rom #(.AW(22), .BASE(22'h3FFFFE)) dut_w (
    .clk(clk), .rst(rst), .ext_rq(ext_rq_w), .ext_addr(ext_addr_w),
    .ext_data(ext_data_w), .ext_ok(ext_ok_w), .flush(flush_w),
    .sys_cs(sys_cs_w), .sys_addr(sys_addr_w), .sys_data(sys_data_w), .sys_ok(sys_ok_w)
  );

  function automatic logic [7:0] rom_byte(input logic [21:0] a);
    if (a == 22'h2468) return 8'hAB;
    if (a == 22'h2469) return 8'hCD;
    return a[7:0] ^ a[15:8] ^ {a[21:16], 2'b01} ^ 8'h3C;
  endfunction

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [21:0] b;
    b = {5'd0, a, 1'b0};
    return {rom_byte(b + 22'd1), rom_byte(b)};
  endfunction

  // System ROM: the cycle after an address change drives a stale sys_ok
  // with wrong data; then a programmable wait before the real byte.
  initial begin
    int          cnt;
    logic [21:0] prev_addr;
    logic        prev_cs;
    cnt = 0; prev_addr = '0; prev_cs = 1'b0;
    sys_ok = 1'b0; sys_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!sys_cs) begin
        sys_ok = 1'b0; sys_data = 8'h00;
      end else if (!prev_cs || sys_addr != prev_addr) begin
        sys_ok   = 1'b1;
        sys_data = ~rom_byte(sys_addr);
        cnt      = (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
      end else if (cnt > 0) begin
        sys_ok = 1'b0; sys_data = 8'hEE; cnt--;
      end else begin
        sys_ok = 1'b1; sys_data = rom_byte(sys_addr);
      end
      prev_cs   = sys_cs;
      prev_addr = sys_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_ok(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (ext_ok) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_rq = 1'b0; flush = 1'b0; ext_addr = 16'h1000;
    ext_rq_w = 1'b0; ext_addr_w = 16'h1000;
    step(); step();
    n_vec++;
    if (sys_cs !== 1'b0 || ext_ok !== 1'b0 || ext_data !== 16'h0 || sys_addr !== 22'h0) begin
      n_err++;
      $display("FAIL reset_state: cs=%b ok=%b data=%h addr=%h, want 0/0/0000/000000",
               sys_cs, ext_ok, ext_data, sys_addr);
    end
    rst = 1'b0;
    step(); step(); step();
    n_vec++;
    if (sys_cs !== 1'b0 || ext_ok !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_rq: cs=%b ok=%b, want 0/0", sys_cs, ext_ok);
    end
    ext_addr = 16'h4321; ext_rq = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    n_vec++;
    if (sys_cs !== 1'b0 || ext_ok !== 1'b0 || ext_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_midfetch: cs=%b ok=%b data=%h, want 0/0/0000", sys_cs, ext_ok, ext_data);
    end
    step(); step();
    rst = 1'b0;
    wait_ok(40);
    n_vec++;
    if (ext_ok !== 1'b1 || ext_data !== word_of(16'h4321)) begin
      n_err++;
      $display("FAIL refetch_after_reset: ok=%b data=%h, want 1/%h", ext_ok, ext_data, word_of(16'h4321));
    end
    ext_rq = 1'b0;
    step();
  endtask

  task automatic test_miss_fixed();
    max_delay = 0;
    ext_addr = 16'h1234; ext_rq = 1'b1;
    settle();
    n_vec++;
    if (ext_ok !== 1'b0) begin
      n_err++; $display("FAIL miss_c0_ok: got %b want 0", ext_ok);
    end
    step();
    n_vec++;
    if (sys_cs !== 1'b1 || sys_addr !== 22'h2468) begin
      n_err++; $display("FAIL miss_lsb_addr: cs=%b addr=%h, want 1/002468", sys_cs, sys_addr);
    end
    step(); step();
    n_vec++;
    if (sys_addr !== 22'h2469) begin
      n_err++; $display("FAIL miss_msb_addr: got %h want 002469", sys_addr);
    end
    step();
    n_vec++;
    if (ext_ok !== 1'b0) begin
      n_err++; $display("FAIL miss_c4_ok: got %b want 0", ext_ok);
    end
    step();
    n_vec++;
    if (ext_ok !== 1'b1 || ext_data !== 16'hCDAB) begin
      n_err++; $display("FAIL miss_c5: ok=%b data=%h, want 1/cdab", ext_ok, ext_data);
    end
    step(); step(); step();
    n_vec++;
    if (ext_ok !== 1'b1 || sys_cs !== 1'b0 || ext_data !== 16'hCDAB) begin
      n_err++; $display("FAIL hit_hold: ok=%b cs=%b data=%h, want 1/0/cdab", ext_ok, sys_cs, ext_data);
    end
  endtask

  task automatic test_variable_latency();
    logic [15:0] a, prev;
    max_delay = 7;
    prev = 16'h1234;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = prev;
      end else begin
        do a = 16'($urandom_range(16'h1000, 16'hFFFF)); while (a == prev);
      end
      ext_addr = a;
      settle();
      if (a == prev) begin
        n_vec++;
        if (ext_ok !== 1'b1 || ext_data !== word_of(a)) begin
          n_err++;
          $display("FAIL rand_hit[%0d]: ok=%b data=%h, want 1/%h", i, ext_ok, ext_data, word_of(a));
        end
        step();
      end else begin
        wait_ok(60);
        n_vec++;
        if (ext_ok !== 1'b1 || ext_data !== word_of(a)) begin
          n_err++;
          $display("FAIL rand_miss[%0d] a=%h: ok=%b data=%h, want 1/%h", i, a, ext_ok, ext_data, word_of(a));
        end
      end
      prev = a;
    end
    max_delay = 0;
  endtask

  task automatic test_addr_change();
    bit saw_first_msb;
    bit early_ok;
    saw_first_msb = 1'b0;
    early_ok      = 1'b0;
    ext_addr = 16'h1000; ext_rq = 1'b1;
    step();
    ext_addr = 16'h2000;
    for (int i = 0; i < 60; i++) begin
      settle();
      if (sys_cs && sys_addr == 22'h2001) saw_first_msb = 1'b1;
      if (ext_ok) begin
        if (!saw_first_msb || sys_addr != 22'h4001) early_ok = 1'b1;
        break;
      end
      step();
    end
    n_vec++;
    if (saw_first_msb !== 1'b1 || early_ok !== 1'b0) begin
      n_err++;
      $display("FAIL addr_change_order: first_fill_seen=%b early_ok=%b, want 1/0", saw_first_msb, early_ok);
    end
    n_vec++;
    if (ext_ok !== 1'b1 || ext_data !== word_of(16'h2000)) begin
      n_err++;
      $display("FAIL addr_change_data: ok=%b data=%h, want 1/%h", ext_ok, ext_data, word_of(16'h2000));
    end
  endtask

  task automatic test_flush();
    ext_addr = 16'h3000; ext_rq = 1'b1;
    settle();
    wait_ok(40);
    n_vec++;
    if (ext_ok !== 1'b1 || ext_data !== word_of(16'h3000)) begin
      n_err++; $display("FAIL flush_prehit: ok=%b data=%h, want 1/%h", ext_ok, ext_data, word_of(16'h3000));
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    n_vec++;
    if (ext_ok !== 1'b0) begin
      n_err++; $display("FAIL flush_drop: ok=%b want 0", ext_ok);
    end
    step();
    n_vec++;
    if (sys_cs !== 1'b1 || sys_addr !== 22'h6000) begin
      n_err++; $display("FAIL flush_refetch: cs=%b addr=%h, want 1/006000", sys_cs, sys_addr);
    end
    wait_ok(40);
    n_vec++;
    if (ext_ok !== 1'b1 || ext_data !== word_of(16'h3000)) begin
      n_err++; $display("FAIL flush_refill: ok=%b data=%h, want 1/%h", ext_ok, ext_data, word_of(16'h3000));
    end
    ext_addr = 16'h3100;
    step(); step(); step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    n_vec++;
    if (ext_ok !== 1'b0 || ext_data !== word_of(16'h3100)) begin
      n_err++;
      $display("FAIL flush_at_msb: ok=%b data=%h, want 0/%h", ext_ok, ext_data, word_of(16'h3100));
    end
    step();
    n_vec++;
    if (sys_cs !== 1'b1 || sys_addr !== 22'h6200) begin
      n_err++; $display("FAIL flush_at_msb_refetch: cs=%b addr=%h, want 1/006200", sys_cs, sys_addr);
    end
    wait_ok(40);
    n_vec++;
    if (ext_ok !== 1'b1 || ext_data !== word_of(16'h3100)) begin
      n_err++; $display("FAIL flush_at_msb_refill: ok=%b data=%h, want 1/%h", ext_ok, ext_data, word_of(16'h3100));
    end
    ext_rq = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    ext_addr_w = 16'hFFFF; ext_rq_w = 1'b1;
    step();
    n_vec++;
    if (sys_cs_w !== 1'b1 || sys_addr_w !== 22'h01FFFC) begin
      n_err++; $display("FAIL wrap_lsb: cs=%b addr=%h, want 1/01fffc", sys_cs_w, sys_addr_w);
    end
    step(); step();
    n_vec++;
    if (sys_addr_w !== 22'h01FFFD) begin
      n_err++; $display("FAIL wrap_msb: addr=%h want 01fffd", sys_addr_w);
    end
    step(); step();
    n_vec++;
    if (ext_ok_w !== 1'b1 || ext_data_w !== 16'h7777 || $isunknown(sys_addr_w)) begin
      n_err++;
      $display("FAIL wrap_done: ok=%b data=%h addr=%h, want 1/7777/known", ext_ok_w, ext_data_w, sys_addr_w);
    end
    ext_rq_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fixed();
    test_variable_latency();
    test_addr_change();
    test_flush();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
